// File: rtl/wam_pkg.sv
// Shared definitions for the countdown display path: segment patterns,
// converter state encoding and the seconds width.
package wam_pkg;

  localparam int unsigned SECONDS_W   = 6;
  localparam int unsigned SECONDS_MAX = 60;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic seconds_in_range(input logic [SECONDS_W-1:0] s);
    return 32'(s) <= SECONDS_MAX;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// 4-bit BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module seg7_encode
  import wam_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/time_display_decoder.sv
// Countdown seconds to two 7-segment digits via a serial shift-add-3 converter,
// with low-time blinking applied at the output.
module time_display_decoder
  import wam_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 25_000_000,
  parameter int unsigned LOW_THRESH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SECONDS_W-1:0] seconds,
  input  logic                 blink_en,
  output logic [6:0]           hex_tens,
  output logic [6:0]           hex_ones,
  output logic                 busy,
  output logic                 time_low
);

  localparam int unsigned SR_W  = 8 + SECONDS_W;
  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  state_e               state_q, state_d;
  logic [SECONDS_W-1:0] seconds_q, seconds_d;
  logic [SECONDS_W-1:0] shown_q, shown_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [SR_W-1:0]      sr_adj;
  logic [2:0]           cnt_q, cnt_d;
  logic [3:0]           tens_q, tens_d;
  logic [3:0]           ones_q, ones_d;
  logic                 dash_q, dash_d;
  logic                 time_low_q, time_low_d;
  logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [6:0]           tens_seg, ones_seg;
  logic                 blank;

  always_comb begin
    state_d     = state_q;
    seconds_d   = seconds;
    shown_d     = shown_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    dash_d      = dash_q;
    time_low_d  = time_low_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    sr_adj = sr_q;
    if (sr_q[SR_W-1 -: 4] >= 4'd5) sr_adj[SR_W-1 -: 4] = sr_q[SR_W-1 -: 4] + 4'd3;
    if (sr_q[SR_W-5 -: 4] >= 4'd5) sr_adj[SR_W-5 -: 4] = sr_q[SR_W-5 -: 4] + 4'd3;

    // Out-of-range values still walk through SHIFT so latency stays fixed;
    // DONE discards the shifted result for them.
    unique case (state_q)
      IDLE: begin
        if (seconds_q != shown_q) begin
          shown_d = seconds_q;
          sr_d    = {8'b0, seconds_q};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(SECONDS_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (seconds_in_range(shown_q)) begin
          tens_d     = sr_q[SR_W-1 -: 4];
          ones_d     = sr_q[SR_W-5 -: 4];
          dash_d     = 1'b0;
          time_low_d = (shown_q != '0) && (32'(shown_q) <= LOW_THRESH);
        end else begin
          dash_d     = 1'b1;
          time_low_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      seconds_q   <= '0;
      shown_q     <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      dash_q      <= 1'b0;
      time_low_q  <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seconds_q   <= seconds_d;
      shown_q     <= shown_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      dash_q      <= dash_d;
      time_low_q  <= time_low_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  seg7_encode u_seg_tens (
    .bcd (tens_q),
    .seg (tens_seg)
  );

  seg7_encode u_seg_ones (
    .bcd (ones_q),
    .seg (ones_seg)
  );

  assign blank    = blink_en & time_low_q & phase_q;
  assign hex_tens = blank ? SEG_BLANK : (dash_q ? SEG_DASH : tens_seg);
  assign hex_ones = blank ? SEG_BLANK : (dash_q ? SEG_DASH : ones_seg);
  assign busy     = (state_q == SHIFT) || (state_q == DONE);
  assign time_low = time_low_q;

endmodule
